pq_sort_ctl: RTL and testbench

PQ_SORT_CTL -- requirements
Module: pq_sort_ctl

---
 rtl/pq_sort_ctl.sv | 119 +++++++++++
 tb/tb_pq_sort_ctl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_sort_ctl.sv
// Batch sort controller wrapped around an external priority queue.
// Each input batch (closed by s_last, or cut at CAP entries) is pushed into the queue
// in LOAD, then popped back out in key order in DRAIN. The pop path is combinational,
// so the queue's head appears on m_kv in the same cycle it becomes valid.
module pq_sort_ctl #(
  parameter int unsigned KW  = 16,
  parameter int unsigned VW  = 16,
  parameter int unsigned CAP = 8,
  localparam int unsigned CW = $clog2(CAP + 1),
  localparam int unsigned DW = KW + VW
) (
  input  logic          clk,
  input  logic          rst,
  // unsorted input stream
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_kv,
  input  logic          s_last,
  // sorted output stream
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_kv,
  output logic          m_last,
  // queue push side
  output logic          pq_ivalid,
  input  logic          pq_irdy,
  output logic [DW-1:0] pq_idata,
  input  logic          pq_full,
  input  logic          pq_busy,
  // queue pop side
  input  logic          pq_ovalid,
  output logic          pq_ordy,
  input  logic [DW-1:0] pq_odata,
  // status
  output logic [CW-1:0] batch_cnt,
  output logic          trunc,
  output logic [15:0]   batches
);

  typedef enum logic [0:0] {StLoad, StDrain} state_e;

  localparam logic [CW-1:0] CapCnt = CW'(CAP);
  localparam logic [CW-1:0] OneCnt = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trunc_q, trunc_d;
  logic [15:0]   batches_q, batches_d;
  logic          accept;
  logic          pop;

  // Handshake decode and next-state; rst gates the handshake outputs so they read zero
  // for the whole reset window, not just after the state register settles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
    batches_d = batches_q;
    s_ready   = 1'b0;
    pq_ivalid = 1'b0;
    pq_idata  = s_kv;
    m_valid   = 1'b0;
    m_kv      = '0;
    m_last    = 1'b0;
    pq_ordy   = 1'b0;
    accept    = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      StLoad: begin
        // pq_full in LOAD is a sizing fault: stall the input rather than overflow
        s_ready   = rst & pq_irdy & ~pq_busy & ~pq_full;
        accept    = s_valid & s_ready;
        pq_ivalid = accept;
        if (accept) begin
          cnt_d = cnt_q + OneCnt;
          if (s_last || (cnt_d == CapCnt)) begin
            state_d = StDrain;
            trunc_d = ~s_last;
          end
        end
      end
      StDrain: begin
        m_valid = rst & pq_ovalid & ~pq_busy;
        m_kv    = pq_odata;
        m_last  = m_valid & (cnt_q == OneCnt);
        pop     = m_valid & m_ready;
        pq_ordy = pop;
        if (pop) begin
          cnt_d = cnt_q - OneCnt;
          if (cnt_q == OneCnt) begin
            state_d   = StLoad;
            batches_d = batches_q + 16'd1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StLoad;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
      batches_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trunc_q   <= trunc_d;
      batches_q <= batches_d;
    end
  end

  assign batch_cnt = cnt_q;
  assign trunc     = trunc_q;
  assign batches   = batches_q;

endmodule

// File: tb/tb_pq_sort_ctl.sv
// Bench for pq_sort_ctl: a behavioural priority queue stands in for the attached queue,
// and a batch-level model (lists of accepted and still-owed entries) predicts every output
// on every cycle. Directed scenarios pin the model with literal expected key sequences.
module tb_pq_sort_ctl;
  localparam int unsigned KW  = 16;
  localparam int unsigned VW  = 16;
  localparam int unsigned CAP = 8;
  localparam int unsigned CW  = $clog2(CAP + 1);
  localparam int unsigned DW  = KW + VW;

  typedef logic [DW-1:0] kv_t;

  localparam int E1_KEYS[3]  = '{1, 4, 5};
  localparam int E1_LASTS[3] = '{0, 0, 1};
  localparam int E2_KEYS[10] = '{3, 4, 5, 6, 7, 8, 9, 10, 1, 2};
  localparam int E3_KEYS[5]  = '{2, 2, 5, 6, 8};
  localparam int E5_KEYS[2]  = '{3, 9};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  kv_t           s_kv = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  kv_t           m_kv;
  logic          m_last;
  logic          pq_ivalid;
  logic          pq_irdy = 1'b0;
  kv_t           pq_idata;
  logic          pq_full = 1'b0;
  logic          pq_busy = 1'b0;
  logic          pq_ovalid = 1'b0;
  logic          pq_ordy;
  kv_t           pq_odata = '0;
  logic [CW-1:0] batch_cnt;
  logic          trunc;
  logic [15:0]   batches;

  pq_sort_ctl #(.KW(KW), .VW(VW), .CAP(CAP)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_kv(s_kv), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_kv(m_kv), .m_last(m_last),
    .pq_ivalid(pq_ivalid), .pq_irdy(pq_irdy), .pq_idata(pq_idata), .pq_full(pq_full),
    .pq_busy(pq_busy), .pq_ovalid(pq_ovalid), .pq_ordy(pq_ordy), .pq_odata(pq_odata),
    .batch_cnt(batch_cnt), .trunc(trunc), .batches(batches)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic int key_of(input kv_t d);
    return int'(d[DW-1:VW]);
  endfunction

  function automatic kv_t mk(input int k, input int v);
    return {KW'(k), VW'(v)};
  endfunction

  // environment: queue contents kept sorted by key, FIFO among equal keys
  kv_t envq[$];
  int  busy_cnt = 0;
  bit  busy_rand = 0;
  bit  irdy_rand = 0;
  bit  valid_rand = 0;
  int  mready_mode = 0;
  kv_t src_kv[$];
  bit  src_last[$];

  // batch-level model
  bit  mdl_drain = 0;
  bit  mdl_trunc = 0;
  int  mdl_batches = 0;
  kv_t cur_in[$];
  kv_t pend[$];
  int  prev_key = -1;
  int  last_cnt = 0;

  // observation records for literal checks
  int  pops[$];
  int  lasts[$];
  int  btrunc[$];
  int  n_hs = 0;
  int  n_acc = 0;

  bit  stall_q = 0;
  kv_t stall_kv = '0;
  bit  stall_last = 0;

  function automatic void env_insert(input kv_t d);
    int pos;
    pos = envq.size();
    for (int i = 0; i < envq.size(); i++) begin
      if (key_of(envq[i]) > key_of(d)) begin
        pos = i;
        break;
      end
    end
    envq.insert(pos, d);
  endfunction

  // Cycle monitor: compares DUT outputs against the model, then advances model and env.
  always @(negedge clk) begin : mon
    bit exp_sr, exp_acc, exp_mv, exp_pop, exp_ml;
    int exp_cnt, idx;
    if (!rst) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_pq_ivalid", pq_ivalid, 0);
      chk("rst_pq_ordy", pq_ordy, 0);
      chk("rst_batch_cnt", batch_cnt, 0);
      chk("rst_trunc", trunc, 0);
      chk("rst_batches", batches, 0);
      mdl_drain = 0; mdl_trunc = 0; mdl_batches = 0;
      cur_in.delete(); pend.delete();
      envq.delete(); busy_cnt = 0; stall_q = 0;
    end else begin
      exp_sr  = !mdl_drain && pq_irdy && !pq_busy && !pq_full;
      exp_acc = exp_sr && s_valid;
      exp_mv  = mdl_drain && pq_ovalid && !pq_busy;
      exp_pop = exp_mv && m_ready;
      exp_ml  = exp_mv && (pend.size() == 1);
      exp_cnt = mdl_drain ? pend.size() : cur_in.size();
      chk("s_ready", s_ready, exp_sr);
      chk("pq_ivalid", pq_ivalid, exp_acc);
      chk("m_valid", m_valid, exp_mv);
      chk("pq_ordy", pq_ordy, exp_pop);
      chk("m_last", m_last, exp_ml);
      chk("batch_cnt", batch_cnt, exp_cnt);
      chk("trunc", trunc, mdl_trunc);
      chk("batches", batches, mdl_batches % 65536);
      if (exp_acc) chk("pq_idata", pq_idata, s_kv);
      if (exp_mv) chk("m_kv", m_kv, pq_odata);
      if (stall_q) begin
        chk("stall_m_valid", m_valid, 1);
        chk("stall_m_kv", m_kv, stall_kv);
        chk("stall_m_last", m_last, stall_last);
      end
      stall_q = m_valid && !m_ready;
      stall_kv = m_kv;
      stall_last = m_last;

      // env reacts to what the DUT actually drives
      if (pq_ivalid && pq_irdy) begin
        env_insert(pq_idata);
        busy_cnt = busy_rand ? int'($urandom_range(0, 2)) : 0;
      end else if (pq_ordy && pq_ovalid) begin
        void'(envq.pop_front());
        busy_cnt = busy_rand ? int'($urandom_range(0, 2)) : 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      if (s_valid && s_ready && src_kv.size() > 0) begin
        void'(src_kv.pop_front());
        void'(src_last.pop_front());
      end

      if (exp_acc) begin
        n_hs++; n_acc++;
        cur_in.push_back(s_kv);
        if (s_last || cur_in.size() == CAP) begin
          mdl_drain = 1;
          mdl_trunc = !s_last;
          pend = cur_in;
          cur_in.delete();
          prev_key = -1;
          last_cnt = 0;
        end
      end
      if (exp_pop) begin
        n_hs++;
        idx = -1;
        for (int i = 0; i < pend.size(); i++) begin
          if (pend[i] == m_kv) begin
            idx = i;
            break;
          end
        end
        chk("pop_in_batch", idx >= 0, 1);
        if (idx >= 0) pend.delete(idx);
        chk("pop_key_order", key_of(m_kv) >= prev_key, 1);
        prev_key = key_of(m_kv);
        pops.push_back(key_of(m_kv));
        lasts.push_back(int'(m_last));
        if (m_last) last_cnt++;
        if (pend.size() == 0) begin
          mdl_drain = 0;
          mdl_batches++;
          chk("m_last_per_batch", last_cnt, 1);
          btrunc.push_back(int'(trunc));
        end
      end
    end
  end

  task automatic drive();
    pq_full   = envq.size() >= CAP;
    pq_irdy   = !pq_full && (!irdy_rand || $urandom_range(0, 3) != 0);
    pq_busy   = busy_cnt > 0;
    pq_ovalid = envq.size() > 0;
    pq_odata  = (envq.size() > 0) ? envq[0] : '0;
    s_valid   = (src_kv.size() > 0) && (!valid_rand || $urandom_range(0, 3) != 0);
    s_kv      = (src_kv.size() > 0) ? src_kv[0] : '0;
    s_last    = (src_last.size() > 0) ? src_last[0] : 1'b0;
    case (mready_mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      default: m_ready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic push_beat(input int k, input int v, input bit last);
    src_kv.push_back(mk(k, v));
    src_last.push_back(last);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    src_kv.delete(); src_last.delete();
    busy_rand = 0; irdy_rand = 0; valid_rand = 0; mready_mode = 0;
    tick();
    tick();
    pops.delete(); lasts.delete(); btrunc.delete();
    n_hs = 0; n_acc = 0;
    rst = 1'b1;
  endtask

  task automatic run_to_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(src_kv.size() == 0 && !mdl_drain && cur_in.size() == 0 && envq.size() == 0)
               && n < budget);
    chk({name, "_done_in_budget"}, n < budget, 1);
  endtask

  initial begin : main
    int n;
    repeat (3) tick();
    rst = 1'b1;

    // Scenario 1: 5,1,4 -> 1,4,5
    do_reset();
    push_beat(5, 1, 0); push_beat(1, 2, 0); push_beat(4, 3, 1);
    run_to_idle("s1", 200);
    chk("s1_npops", pops.size(), 3);
    for (int i = 0; i < 3 && i < pops.size(); i++) begin
      chk("s1_key", pops[i], E1_KEYS[i]);
      chk("s1_last", lasts[i], E1_LASTS[i]);
    end
    chk("s1_batches", batches, 1);
    chk("s1_trunc", trunc, 0);
    chk("s1_batch_cnt", batch_cnt, 0);

    // Scenario 2: ten beats 10..1 split at CAP
    do_reset();
    for (int i = 0; i < 10; i++) push_beat(10 - i, i, i == 9);
    run_to_idle("s2", 400);
    chk("s2_npops", pops.size(), 10);
    for (int i = 0; i < 10 && i < pops.size(); i++) chk("s2_key", pops[i], E2_KEYS[i]);
    chk("s2_nbatch", btrunc.size(), 2);
    if (btrunc.size() == 2) begin
      chk("s2_trunc_a", btrunc[0], 1);
      chk("s2_trunc_b", btrunc[1], 0);
    end
    chk("s2_batches", batches, 2);

    // Scenario 3: m_ready toggling in DRAIN
    do_reset();
    mready_mode = 1;
    push_beat(6, 1, 0); push_beat(2, 2, 0); push_beat(8, 3, 0);
    push_beat(2, 4, 0); push_beat(5, 5, 1);
    run_to_idle("s3", 400);
    chk("s3_npops", pops.size(), 5);
    for (int i = 0; i < 5 && i < pops.size(); i++) chk("s3_key", pops[i], E3_KEYS[i]);
    chk("s3_batches", batches, 1);

    // Scenario 4: single-beat batch
    do_reset();
    push_beat(7, 7, 1);
    run_to_idle("s4", 100);
    chk("s4_npops", pops.size(), 1);
    if (pops.size() == 1) begin
      chk("s4_key", pops[0], 7);
      chk("s4_last", lasts[0], 1);
    end
    chk("s4_handshakes", n_hs, 2);
    chk("s4_batches", batches, 1);

    // Scenario 5: reset mid-LOAD
    do_reset();
    push_beat(11, 1, 0); push_beat(12, 2, 0); push_beat(13, 3, 0); push_beat(14, 4, 1);
    n = 0;
    while (n_acc < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("s5_two_accepted", n_acc, 2);
    rst = 1'b0;
    #1;
    chk("s5_async_s_ready", s_ready, 0);
    chk("s5_async_pq_ivalid", pq_ivalid, 0);
    chk("s5_async_batch_cnt", batch_cnt, 0);
    chk("s5_async_m_valid", m_valid, 0);
    src_kv.delete(); src_last.delete();
    tick();
    tick();
    pops.delete(); lasts.delete();
    rst = 1'b1;
    push_beat(9, 1, 0); push_beat(3, 2, 1);
    run_to_idle("s5", 200);
    chk("s5_npops", pops.size(), 2);
    for (int i = 0; i < 2 && i < pops.size(); i++) chk("s5_key", pops[i], E5_KEYS[i]);
    chk("s5_batches", batches, 1);

    // Scenario 6: 1000 random beats with random last, gaps, busy and backpressure
    do_reset();
    busy_rand = 1; irdy_rand = 1; valid_rand = 1; mready_mode = 2;
    for (int i = 0; i < 1000; i++)
      push_beat(int'($urandom_range(0, 15)), int'($urandom), (i == 999) || ($urandom_range(0, 4) == 0));
    run_to_idle("s6", 60000);
    chk("s6_npops", pops.size(), 1000);
    chk("s6_batches", batches, mdl_batches % 65536);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
